// File: rtl/trigger_buffer_manager_n.sv
// Round-robin trigger-to-analog-buffer manager: it arbitrates masked trigger
// sources into NUM_BUFFERS HOLD buffers and enforces a post-trigger holdoff.
module trigger_buffer_manager_n #(
  parameter int NUM_BUFFERS = 4,
  parameter int NUM_TRIG    = 4,
  parameter int BUF_BITS    = 2,
  parameter int HOLDOFF     = 16
) (
  input  logic                   clk250_i,
  input  logic                   rst_i,
  input  logic [NUM_TRIG-1:0]    trig_i,
  input  logic [NUM_TRIG-1:0]    trig_en_i,
  input  logic                   clear_i,
  input  logic [BUF_BITS-1:0]    clear_buffer_i,
  output logic                   digitize_o,
  output logic [BUF_BITS-1:0]    digitize_buffer_o,
  output logic [NUM_TRIG-1:0]    digitize_source_o,
  output logic [NUM_BUFFERS-1:0] buffer_status_o,
  output logic [NUM_BUFFERS-1:0] HOLD_o,
  output logic                   dead_o,
  output logic [BUF_BITS:0]      occupancy_o,
  output logic [15:0]            lost_count_o
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [BUF_BITS-1:0] LAST_BUF = BUF_BITS'(NUM_BUFFERS - 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(HOLDOFF - 1);

  typedef enum logic {S_IDLE, S_HOLDOFF} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BUF_BITS-1:0]    wr_ptr_q, wr_ptr_d;
  logic [NUM_BUFFERS-1:0] status_q, status_d;
  logic [15:0]            lost_q, lost_d;
  logic                   dig_q, dig_d;
  logic [BUF_BITS-1:0]    dig_buf_q, dig_buf_d;
  logic [NUM_TRIG-1:0]    dig_src_q, dig_src_d;
  logic [BUF_BITS:0]      occ_q, occ_d;

  logic [NUM_TRIG-1:0]    masked;
  logic                   req;
  logic                   dead;
  logic                   accept;

  assign masked = trig_i & trig_en_i;
  assign req    = |masked;
  // Strict round-robin: a held buffer at wr_ptr blocks even if others are free.
  assign dead   = (state_q == S_HOLDOFF) | status_q[wr_ptr_q];
  assign accept = req & ~dead;

  // NOTE: every variable gets its default first so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    status_d  = status_q;
    lost_d    = lost_q;
    dig_d     = accept;
    dig_buf_d = dig_buf_q;
    dig_src_d = dig_src_q;
    occ_d     = '0;

    if (clear_i && (int'(clear_buffer_i) < NUM_BUFFERS)) begin
      status_d[clear_buffer_i] = 1'b0;
    end

    if (accept) begin
      status_d[wr_ptr_q] = 1'b1;
      dig_buf_d          = wr_ptr_q;
      dig_src_d          = masked;
      wr_ptr_d           = (wr_ptr_q == LAST_BUF) ? '0 : wr_ptr_q + BUF_BITS'(1);
      state_d            = S_HOLDOFF;
      cnt_d              = CNT_LOAD;
    end else if (state_q == S_HOLDOFF) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (req && dead && (lost_q != 16'hFFFF)) begin
      lost_d = lost_q + 16'd1;
    end

    // Popcount of the pre-edge status, so occupancy trails status by a cycle.
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      occ_d = occ_d + (BUF_BITS + 1)'(status_q[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      status_q  <= '0;
      lost_q    <= '0;
      dig_q     <= 1'b0;
      dig_buf_q <= '0;
      dig_src_q <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      status_q  <= status_d;
      lost_q    <= lost_d;
      dig_q     <= dig_d;
      dig_buf_q <= dig_buf_d;
      dig_src_q <= dig_src_d;
      occ_q     <= occ_d;
    end
  end

  assign digitize_o        = dig_q;
  assign digitize_buffer_o = dig_buf_q;
  assign digitize_source_o = dig_src_q;
  assign buffer_status_o   = status_q;
  assign HOLD_o            = status_q;
  assign dead_o            = dead;
  assign occupancy_o       = occ_q;
  assign lost_count_o      = lost_q;

endmodule

// File: doc/trigger_buffer_manager_n.md
# trigger_buffer_manager_n

Parametrised successor to the 4-buffer, 4-source HOLD manager in the trigger interface. It runs in the 250 MHz trigger domain, between the trigger sources (RF, PPS1, PPS2, soft) and the event generator / SURF HOLD fan-out. It arbitrates masked trigger sources into a round-robin pool of `NUM_BUFFERS` analog buffers and asserts per-buffer HOLD. It issues a one-cycle digitize command carrying the buffer index and source pattern, and enforces a programmable post-trigger holdoff. New against the previous generation: arbitrary buffer/source count, per-source enable mask, occupancy output and a saturating lost-trigger counter.

## Interface
Parameters:
- `NUM_BUFFERS`, default 4: number of analog buffers; range 2..16.
- `NUM_TRIG`, default 4: number of trigger sources.
- `BUF_BITS`, default 2: buffer index width; requires 2^BUF_BITS >= NUM_BUFFERS.
- `HOLDOFF`, default 16: minimum dead cycles after each accepted trigger; must be >= 1.

Ports:
- `clk250_i`  in  1  trigger clock. The only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `trig_i`  in  NUM_TRIG  trigger requests, sampled every cycle; bit 0 is the RF trigger.
- `trig_en_i`  in  NUM_TRIG  per-source enable mask; quasi-static.
- `clear_i`  in  1  one-cycle pulse that releases buffer `clear_buffer_i`.
- `clear_buffer_i`  in  BUF_BITS  index of the buffer to release.
- `digitize_o`  out  1  one-cycle digitize command.
- `digitize_buffer_o`  out  BUF_BITS  buffer being digitized; held until the next accept.
- `digitize_source_o`  out  NUM_TRIG  `trig_i & trig_en_i` captured at accept; held until the next accept.
- `buffer_status_o`  out  NUM_BUFFERS  1 = buffer occupied.
- `HOLD_o`  out  NUM_BUFFERS  per-buffer HOLD to the SURFs; equals `buffer_status_o`.
- `dead_o`  out  1  trigger cannot be accepted this cycle.
- `occupancy_o`  out  BUF_BITS+1  popcount of `buffer_status_o`.
- `lost_count_o`  out  16  masked triggers rejected while dead; saturates.

## Operation
- Registered state:
  - `wr_ptr` (BUF_BITS): next buffer to fill.
  - `state`: IDLE or HOLDOFF.
  - holdoff counter: width sufficient for `HOLDOFF`.
  - `status`: NUM_BUFFERS bits.
  - lost counter: 16 bits.
- `req` = OR-reduction of (`trig_i & trig_en_i`).
- `dead_o` = (`state` == HOLDOFF) OR `status[wr_ptr]`. This is combinational from registers only.
- Accept condition: `req` AND NOT `dead_o`. On an accept edge:
  - set `status[wr_ptr]`;
  - register `digitize_o`=1, `digitize_buffer_o`=`wr_ptr`, `digitize_source_o`=`trig_i & trig_en_i`;
  - `wr_ptr` <= (`wr_ptr`+1) mod NUM_BUFFERS, wrapping from NUM_BUFFERS-1 to 0;
  - `state` <= HOLDOFF, counter <= HOLDOFF-1.
- HOLDOFF state: the counter decrements each cycle. When the counter equals 0, `state` <= IDLE on that edge.
- Strict round-robin: if `status[wr_ptr]` is set, the block is dead even when other buffers are free. This preserves readout order.
- Clear: when `clear_i` is high and `clear_buffer_i` < NUM_BUFFERS, clear `status[clear_buffer_i]`.
  - Clearing a free buffer is a no-op.
  - An out-of-range index is ignored.
- Simultaneous clear of `wr_ptr` and a trigger in the same cycle: the trigger is rejected, because dead is evaluated on pre-edge status. The clear takes effect.
- Clear and accept on different buffers in the same cycle: both take effect.
- Lost counter: increments by 1 on every cycle with `req` AND `dead_o`. It saturates at 0xFFFF and is cleared only by `rst_i`.
- `digitize_o` is high for exactly one cycle per accept and is never high on consecutive cycles (HOLDOFF >= 1).

## Timing
- Reset (async assert):
  - all outputs 0;
  - `wr_ptr`=0, `state`=IDLE, `status`=0, lost counter=0.
  - Therefore `dead_o`=0 immediately.
- Reset deassertion is assumed synchronised externally.
- Reset mid-holdoff or with buffers held: every HOLD drops immediately, with no digitize.
- Latency from `trig_i` sampled at edge T:
  - `digitize_o`, `HOLD_o` bit and `buffer_status_o` bit are high after edge T (cycle T+1);
  - `dead_o` is high from cycle T+1.
- Holdoff: `dead_o` is high for exactly HOLDOFF cycles (T+1..T+HOLDOFF). The next accept is possible at edge T+HOLDOFF+1, provided the next buffer is free.
- Clear latency: a `clear_i` at edge C drops `HOLD_o` from cycle C+1. A trigger at edge C+1 into that buffer is accepted.
- `occupancy_o` is a registered popcount, one cycle behind `status`.

## Test plan
- Reset, all masks 1, pulse `trig_i`=4'b0001 at T -> at T+1: `digitize_o`=1 for one cycle, `digitize_buffer_o`=0, `digitize_source_o`=0001, `HOLD_o`=0001; `dead_o` high for exactly 16 cycles.
- Four triggers spaced 20 cycles apart, no clears -> buffers 0,1,2,3 held, `occupancy_o`=4. A fifth trigger is rejected, `dead_o` stays 1, `lost_count_o`=1.
- From the full state, clear buffer 2, then trigger -> rejected (`wr_ptr`=0 is still held). Then clear buffer 0 and trigger -> `digitize_buffer_o`=0.
- `trig_en_i`=1110, `trig_i`=0001 -> no digitize and no lost increment. Then `trig_i`=1001 -> `digitize_source_o`=1000.
- In the same cycle, clear buffer 0 (held, `wr_ptr`=0) and assert a trigger -> trigger rejected, `lost_count_o`+1. A trigger on the next cycle is accepted into buffer 0.
- Hold `trig_i` high continuously for 70000 cycles with no clears -> `lost_count_o` saturates at 0xFFFF. Assert `rst_i` mid-holdoff -> all outputs 0 asynchronously.
